cordic_rr_sched: RTL and testbench
==================================

// Module: cordic_rr_sched
// PURPOSE
//  Shares one fixed-latency CORDIC pipeline (chain of cordic stages, NCO or ANGLE mode)
//  between NREQ requesters. Round-robin arbitration of valid/ready requests, issue into
//  the pipeline, tag tracking through a LAT-deep delay line, one-hot return routing.
//  Pause/drain handshake quiesces the pipeline so a host can reconfigure it safely.
// PARAMETERS
//  NREQ  4   number of requesters (2..8)
//  DW    20  x/y data width
//  AW    20  angle width; info width is AW+2
//  LAT   19  cycles from cd_dv to matching cr_dv (one per CORDIC stage)
// PORTS
//  clk        in   1              clock
//  rst        in   1              synchronous, active-high reset
//  req_valid  in   NREQ           request valid per requester
//  req_ready  out  NREQ           grant, one-hot or zero (combinational)
//  req_en     in   NREQ           per-requester arbitration enable mask
//  req_x      in   NREQ*DW        packed x operands, requester i at [i*DW +: DW]
//  req_y      in   NREQ*DW        packed y operands
//  req_z      in   NREQ*AW        packed z operands
//  req_info   in   NREQ*(AW+2)    packed info (target angle / sideband)
//  cd_dv/cd_x/cd_y/cd_z/cd_info  out 1/DW/DW/AW/AW+2  pipeline input, registered
//  cr_dv/cr_x/cr_y/cr_z  in  1/DW/DW/AW  pipeline output
//  rsp_valid  out  NREQ           one-hot result strobe, no backpressure
//  rsp_x/rsp_y/rsp_z  out DW/DW/AW  shared result bus
//  pause_req  in   1              level: stop issuing and drain
//  pause_ack  out  1              high while paused and pipeline empty
//  inflight   out  clog2(LAT+3)   accepted but not yet retired transactions
//  err_orphan out  1              sticky: cr_dv seen with no tag
//  err_lost   out  1              sticky: tag retired with cr_dv low
// BEHAVIOUR
//  - Reset: all outputs 0, rr pointer = NREQ-1 (req 0 wins first), tag line cleared,
//    state RUN. rst mid-operation discards all in-flight tags; late cr_dv is ignored
//    for LAT+1 cycles after reset (no err_orphan during that window).
//  - Arbitration (RUN only): eligible = req_valid & req_en. Scan from ptr+1 modulo NREQ;
//    first eligible gets req_ready. At most one grant/cycle. On grant, ptr <= granted idx.
//    No grant if no eligible requester; ptr then unchanged.
//  - Issue: the grant cycle captures the operands. Next cycle cd_dv=1 with that data;
//    otherwise cd_dv=0 and data holds. Sustained throughput is 1/cycle.
//  - Tag line: LAT-deep shift of {v, id[clog2(NREQ)-1:0]}; entry = {cd_dv, id}.
//  - Retire: tag output v=1 and cr_dv=1 -> next cycle rsp_valid[id]=1, rsp_* = cr_*
//    (registered). Total latency is LAT+2 clocks from grant to rsp_valid.
//    v=1, cr_dv=0 -> set err_lost, no rsp. v=0, cr_dv=1 -> set err_orphan, no rsp.
//  - inflight: +1 on grant, -1 when tag v exits. Both in one cycle -> unchanged.
//  - FSM: RUN --pause_req--> DRAIN (grants blocked the same cycle pause_req is seen).
//    DRAIN --inflight==0--> PAUSED (pause_ack=1). PAUSED --!pause_req--> RUN.
//    DRAIN --!pause_req--> RUN. When inflight==0 and pause_req is set, RUN->DRAIN->PAUSED
//    takes 2 cycles.
//  - Error flags clear only on rst.
// TESTING
//  1. Single req 2, x=0x10000 y=0 z=0: req_ready[2] in the same cycle; cd_dv 1 cycle later;
//     rsp_valid=4'b0100 at grant+LAT+2.
//  2. All 4 valid continuously after reset: grants cycle 0,1,2,3,0,... and the rsp
//     order matches, 1 result/cycle.
//  3. req_en=4'b1011, all valid: requester 2 is never granted; order 0,1,3,0.
//  4. 5 grants, then pause_req: no further grants; pause_ack rises after the last rsp
//     (inflight 0); drop pause_req -> grants resume next cycle.
//  5. Inject cr_dv with the tag line empty -> err_orphan=1; suppress one cr_dv
//     -> err_lost=1; no rsp_valid in either case.
//  6. rst mid-stream with 10 in flight: outputs 0, inflight 0, no rsp_valid and
//     no err flags from late cr_dv.

Source files
------------

// File: rtl/cordic_rr_sched.sv
// cordic_rr_sched: round-robin front end that shares one fixed-latency CORDIC
// pipeline between NREQ requesters. Issues one request per cycle, tracks the
// requester id through a LAT-deep tag line, and routes each result back one-hot.
// A pause/drain handshake lets a host quiesce the pipeline before reconfiguring it.
module cordic_rr_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 20,
  parameter int AW   = 20,
  parameter int LAT  = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ*DW-1:0]       req_x,
  input  logic [NREQ*DW-1:0]       req_y,
  input  logic [NREQ*AW-1:0]       req_z,
  input  logic [NREQ*(AW+2)-1:0]   req_info,
  output logic                     cd_dv,
  output logic [DW-1:0]            cd_x,
  output logic [DW-1:0]            cd_y,
  output logic [AW-1:0]            cd_z,
  output logic [AW+1:0]            cd_info,
  input  logic                     cr_dv,
  input  logic [DW-1:0]            cr_x,
  input  logic [DW-1:0]            cr_y,
  input  logic [AW-1:0]            cr_z,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DW-1:0]            rsp_x,
  output logic [DW-1:0]            rsp_y,
  output logic [AW-1:0]            rsp_z,
  input  logic                     pause_req,
  output logic                     pause_ack,
  output logic [$clog2(LAT+3)-1:0] inflight,
  output logic                     err_orphan,
  output logic                     err_lost
);
  localparam int IDW = $clog2(NREQ);
  localparam int IFW = $clog2(LAT+3);
  localparam int BW  = $clog2(LAT+2);

  typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

  state_t                 state_reg;
  logic [IDW-1:0]         ptr_reg;
  logic [IDW-1:0]         cd_id_reg;
  logic [LAT-1:0][IDW:0]  tag_reg;
  logic [BW-1:0]          blank_reg;

  logic [NREQ-1:0]        eligible;
  logic                   grant_any;
  logic [IDW-1:0]         grant_idx;
  logic [IDW-1:0]         cand;
  logic                   tag_v;
  logic [IDW-1:0]         tag_id;

  logic [DW-1:0]          x_arr    [NREQ];
  logic [DW-1:0]          y_arr    [NREQ];
  logic [AW-1:0]          z_arr    [NREQ];
  logic [AW+1:0]          info_arr [NREQ];

  // Unpack the flat operand buses into per-requester views.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi]    = req_x[gi*DW +: DW];
    assign y_arr[gi]    = req_y[gi*DW +: DW];
    assign z_arr[gi]    = req_z[gi*AW +: AW];
    assign info_arr[gi] = req_info[gi*(AW+2) +: AW+2];
  end

  // (base + off) modulo NREQ, for off in 1..NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  assign tag_v  = tag_reg[LAT-1][IDW];
  assign tag_id = tag_reg[LAT-1][IDW-1:0];

  // Round-robin pick: scan from the requester after the last winner; grants only in RUN
  // with no pause request pending, so a pause blocks issue in the cycle it is raised.
  always_comb begin
    eligible  = req_valid & req_en;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    req_ready = '0;
    if (!rst && state_reg == RUN && !pause_req) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = wrap_idx(ptr_reg, k);
        if (!grant_any && eligible[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  // Issue register: capture the winner's operands; data holds when nothing issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg   <= IDW'(NREQ-1);
      cd_dv     <= 1'b0;
      cd_id_reg <= '0;
      cd_x      <= '0;
      cd_y      <= '0;
      cd_z      <= '0;
      cd_info   <= '0;
    end else begin
      cd_dv <= grant_any;
      if (grant_any) begin
        ptr_reg   <= grant_idx;
        cd_id_reg <= grant_idx;
        cd_x      <= x_arr[grant_idx];
        cd_y      <= y_arr[grant_idx];
        cd_z      <= z_arr[grant_idx];
        cd_info   <= info_arr[grant_idx];
      end
    end
  end

  // Tag line: shifts {cd_dv, id} alongside the pipeline so the exit lines up with cr_dv.
  always_ff @(posedge clk) begin
    if (rst) tag_reg <= '0;
    else     tag_reg <= {tag_reg[LAT-2:0], {cd_dv, cd_id_reg}};
  end

  // Retire and error detection; a blanking window after reset hides stale pipeline output.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_x      <= '0;
      rsp_y      <= '0;
      rsp_z      <= '0;
      err_orphan <= 1'b0;
      err_lost   <= 1'b0;
      blank_reg  <= BW'(LAT+1);
    end else begin
      rsp_valid <= '0;
      if (blank_reg != '0) blank_reg <= blank_reg - BW'(1);
      if (tag_v && cr_dv) begin
        rsp_valid[tag_id] <= 1'b1;
        rsp_x             <= cr_x;
        rsp_y             <= cr_y;
        rsp_z             <= cr_z;
      end
      if (tag_v && !cr_dv) err_lost <= 1'b1;
      if (!tag_v && cr_dv && blank_reg == '0) err_orphan <= 1'b1;
    end
  end

  // Outstanding count: +1 per grant, -1 per tag leaving the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({grant_any, tag_v})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Pause FSM: RUN -> DRAIN on request, DRAIN -> PAUSED once empty, back to RUN on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      pause_ack <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          pause_ack <= 1'b0;
          if (pause_req) state_reg <= DRAIN;
        end
        DRAIN: begin
          if (!pause_req) begin
            state_reg <= RUN;
          end else if (inflight == '0) begin
            state_reg <= PAUSED;
            pause_ack <= 1'b1;
          end
        end
        PAUSED: begin
          if (!pause_req) begin
            state_reg <= RUN;
            pause_ack <= 1'b0;
          end
        end
        default: begin
          state_reg <= RUN;
          pause_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rr_sched.sv
// Directed bench for cordic_rr_sched: a delay-line stand-in for the CORDIC pipeline
// with hooks to inject or suppress its output valid.
module tb_cordic_rr_sched;
  localparam int NREQ = 4;
  localparam int DW   = 20;
  localparam int AW   = 20;
  localparam int LAT  = 19;
  localparam int IFW  = $clog2(LAT+3);

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid, req_ready, req_en;
  logic [NREQ*DW-1:0]     req_x, req_y;
  logic [NREQ*AW-1:0]     req_z;
  logic [NREQ*(AW+2)-1:0] req_info;
  logic                   cd_dv;
  logic [DW-1:0]          cd_x, cd_y;
  logic [AW-1:0]          cd_z;
  logic [AW+1:0]          cd_info;
  logic                   cr_dv;
  logic [DW-1:0]          cr_x, cr_y;
  logic [AW-1:0]          cr_z;
  logic [NREQ-1:0]        rsp_valid;
  logic [DW-1:0]          rsp_x, rsp_y;
  logic [AW-1:0]          rsp_z;
  logic                   pause_req, pause_ack;
  logic [IFW-1:0]         inflight;
  logic                   err_orphan, err_lost;
  logic                   inject, suppress;

  int n_assert = 0;
  int n_fail   = 0;

  cordic_rr_sched #(.NREQ(NREQ), .DW(DW), .AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_en(req_en),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_info(req_info),
    .cd_dv(cd_dv), .cd_x(cd_x), .cd_y(cd_y), .cd_z(cd_z), .cd_info(cd_info),
    .cr_dv(cr_dv), .cr_x(cr_x), .cr_y(cr_y), .cr_z(cr_z),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .pause_req(pause_req), .pause_ack(pause_ack), .inflight(inflight),
    .err_orphan(err_orphan), .err_lost(err_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipeline stand-in: pure LAT-cycle delay of the issue bus.
  bit          pipe_dv [LAT];
  bit [DW-1:0] pipe_x  [LAT];
  bit [DW-1:0] pipe_y  [LAT];
  bit [AW-1:0] pipe_z  [LAT];

  always @(posedge clk) begin
    pipe_dv[0] <= cd_dv;
    pipe_x[0]  <= cd_x;
    pipe_y[0]  <= cd_y;
    pipe_z[0]  <= cd_z;
    for (int i = 1; i < LAT; i++) begin
      pipe_dv[i] <= pipe_dv[i-1];
      pipe_x[i]  <= pipe_x[i-1];
      pipe_y[i]  <= pipe_y[i-1];
      pipe_z[i]  <= pipe_z[i-1];
    end
  end

  assign cr_dv = (pipe_dv[LAT-1] & ~suppress) | inject;
  assign cr_x  = pipe_x[LAT-1];
  assign cr_y  = pipe_y[LAT-1];
  assign cr_z  = pipe_z[LAT-1];

  function automatic logic [31:0] xval(input logic [1:0] id);
    case (id)
      2'd0:    return 32'h00abc;
      2'd1:    return 32'h11111;
      2'd2:    return 32'h10000;
      default: return 32'h33333;
    endcase
  endfunction

  function automatic logic [31:0] yval(input logic [1:0] id);
    case (id)
      2'd0:    return 32'h0a0a0;
      2'd1:    return 32'h0b0b0;
      2'd2:    return 32'h00000;
      default: return 32'h0d0d0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1; req_valid = '0; pause_req = 1'b0; inject = 1'b0; suppress = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      req_valid = '0;
    end
  endtask

  // All requesters valid for n cycles under mask en_mask; order holds expected ids, 2 bits each.
  task automatic burst(input int n, input logic [3:0] en_mask, input logic [15:0] order, input string tag);
    logic [1:0] id;
    for (int c = 0; c < n + LAT + 3; c++) begin
      @(negedge clk);
      req_valid = (c < n) ? 4'hF : 4'h0;
      req_en    = en_mask;
      #1;
      if (c < n) begin
        id = order[2*c +: 2];
        chk({tag, "_grant"}, 32'(req_ready), 32'(1) << id);
      end else begin
        chk({tag, "_idle"}, 32'(req_ready), 32'h0);
      end
      if (c >= LAT + 2 && c < n + LAT + 2) begin
        id = order[2*(c-LAT-2) +: 2];
        chk({tag, "_rsp"}, 32'(rsp_valid), 32'(1) << id);
        chk({tag, "_rsp_x"}, 32'(rsp_x), xval(id));
        chk({tag, "_rsp_y"}, 32'(rsp_y), yval(id));
      end else begin
        chk({tag, "_norsp"}, 32'(rsp_valid), 32'h0);
      end
    end
    chk({tag, "_inflight0"}, 32'(inflight), 32'h0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_en = 4'hF; pause_req = 1'b0;
    inject = 1'b0; suppress = 1'b0;
    req_x    = {20'h33333, 20'h10000, 20'h11111, 20'h00abc};
    req_y    = {20'h0d0d0, 20'h00000, 20'h0b0b0, 20'h0a0a0};
    req_z    = {20'h01237, 20'h00000, 20'h01235, 20'h01234};
    req_info = {22'h3, 22'h2, 22'h1, 22'h0};

    // Reset state
    do_reset(LAT + 2);
    #1;
    chk("rst_cd_dv", 32'(cd_dv), 32'h0);
    chk("rst_cd_x", 32'(cd_x), 32'h0);
    chk("rst_rsp", 32'(rsp_valid), 32'h0);
    chk("rst_ack", 32'(pause_ack), 32'h0);
    chk("rst_inflight", 32'(inflight), 32'h0);
    chk("rst_orphan", 32'(err_orphan), 32'h0);
    chk("rst_lost", 32'(err_lost), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h0);

    // 1: single request from requester 2
    @(negedge clk); req_valid = 4'b0100; req_en = 4'hF; #1;
    chk("t1_grant", 32'(req_ready), 32'h4);
    chk("t1_cd_dv_pre", 32'(cd_dv), 32'h0);
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk); req_valid = '0; #1;
      if (c == 1) begin
        chk("t1_cd_dv", 32'(cd_dv), 32'h1);
        chk("t1_cd_x", 32'(cd_x), 32'h10000);
        chk("t1_inflight1", 32'(inflight), 32'h1);
      end
      if (c == 2) chk("t1_cd_dv_drop", 32'(cd_dv), 32'h0);
      if (c == LAT + 2) begin
        chk("t1_rsp", 32'(rsp_valid), 32'h4);
        chk("t1_rsp_x", 32'(rsp_x), 32'h10000);
        chk("t1_inflight0", 32'(inflight), 32'h0);
      end else begin
        chk("t1_norsp", 32'(rsp_valid), 32'h0);
      end
    end

    // 2: all valid from reset, order 0,1,2,3,0,1,2,3
    do_reset(2);
    burst(8, 4'hF, 16'hE4E4, "t2");

    // 3: requester 2 masked, order 0,1,3,0
    do_reset(2);
    burst(4, 4'b1011, 16'h0034, "t3");

    // 4: five grants, then pause/drain/resume
    do_reset(2);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      req_valid = 4'hF; req_en = 4'hF;
      pause_req = (c >= 5 && c < 29);
      #1;
      if (c < 5) chk("t4_grant", 32'(req_ready), 32'(1) << (c % 4));
      else if (c < 30) chk("t4_blocked", 32'(req_ready), 32'h0);
      if (c == 5) chk("t4_inflight5", 32'(inflight), 32'h5);
      if (c == 25) chk("t4_last_rsp", 32'(rsp_valid), 32'h1);
      if (c >= 5 && c <= 29) chk("t4_ack", 32'(pause_ack), (c >= 26) ? 32'h1 : 32'h0);
      if (c == 30) begin
        chk("t4_resume", 32'(req_ready), 32'h2);
        chk("t4_ack_drop", 32'(pause_ack), 32'h0);
      end
      if (c == 31) chk("t4_resume2", 32'(req_ready), 32'h4);
    end
    idle(LAT + 4);

    // 5: orphan result, then a lost result
    @(negedge clk); inject = 1'b1;
    @(negedge clk); inject = 1'b0; #1;
    chk("t5_orphan", 32'(err_orphan), 32'h1);
    chk("t5_orphan_norsp", 32'(rsp_valid), 32'h0);
    chk("t5_lost_clear", 32'(err_lost), 32'h0);
    suppress = 1'b1;
    @(negedge clk); req_valid = 4'b0001; #1;
    chk("t5_grant", 32'(req_ready), 32'h1);
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk); req_valid = '0; #1;
      chk("t5_norsp", 32'(rsp_valid), 32'h0);
      if (c == LAT + 1) chk("t5_lost_pre", 32'(err_lost), 32'h0);
      if (c == LAT + 2) chk("t5_lost", 32'(err_lost), 32'h1);
    end
    suppress = 1'b0;

    // 6: reset with ten transactions in flight
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); req_valid = 4'hF; req_en = 4'hF;
    end
    @(negedge clk); req_valid = '0; rst = 1'b1; #1;
    chk("t6_inflight10", 32'(inflight), 32'd10);
    chk("t6_orphan_sticky", 32'(err_orphan), 32'h1);
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_cd_dv", 32'(cd_dv), 32'h0);
    chk("t6_inflight0", 32'(inflight), 32'h0);
    chk("t6_orphan_clr", 32'(err_orphan), 32'h0);
    chk("t6_lost_clr", 32'(err_lost), 32'h0);
    chk("t6_ack", 32'(pause_ack), 32'h0);
    for (int c = 0; c < LAT + 5; c++) begin
      @(negedge clk); #1;
      chk("t6_norsp", 32'(rsp_valid), 32'h0);
      chk("t6_no_orphan", 32'(err_orphan), 32'h0);
      chk("t6_no_lost", 32'(err_lost), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
